// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Default widths match the core's 9-bit fetch PC and 32-bit instructions.
package fetch_queue_pkg;

    localparam int FQ_PC_W  = 9;
    localparam int FQ_INS_W = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FQ_PC_W-1:0]  pc;
        logic [FQ_INS_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// IF/ID handshake between the fetch queue (master) and the decode stage (slave).
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int PC_W  = FQ_PC_W,
    parameter int INS_W = FQ_INS_W
);

    logic             if_valid;
    logic             if_ready;
    logic [PC_W-1:0]  if_pc;
    logic [INS_W-1:0] if_instr;

    modport master (output if_valid, if_pc, if_instr, input  if_ready);
    modport slave  (input  if_valid, if_pc, if_instr, output if_ready);

endinterface

// File: rtl/fetch_queue_fifo.sv
// Circular-buffer FIFO with wrap-bit pointers; clear has priority over push and pop.
module fetch_fifo #(
    parameter  int W     = 41,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_pop;

    assign count  = wr_ptr - rd_ptr;
    assign do_pop = pop && (count != '0);
    assign dout   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // At full, a same-edge push lands in the slot being popped, which is safe.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Upstream credit counting must keep a lone push away from a full buffer.
    assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && !clear && count == (AW+1)'(DEPTH)));

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency imem reads,
// and queues {pc, instr} pairs for the IF/ID register with redirect/halt control.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int PC_W  = FQ_PC_W,
    parameter  int INS_W = FQ_INS_W,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             halt,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    fetch_queue_if.master    ifid,
    output logic [CW-1:0]    q_count
);

    logic [PC_W-1:0]       pc_q;
    logic [PC_W-1:0]       req_pc_q;
    logic                  inflight;
    logic                  drop;
    logic                  valid;
    logic                  pop;
    logic                  push;
    logic [CW:0]           credit;
    logic [PC_W+INS_W-1:0] head;

    assign valid = (q_count != '0);
    assign pop   = valid && ifid.if_ready;

    // Slots already committed: queued entries plus the outstanding read, less this cycle's pop.
    assign credit   = {1'b0, q_count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign imem_req = reset && !redirect && !halt && (credit < (CW+1)'(DEPTH));
    assign imem_addr = pc_q;

    assign push = inflight && !drop && !redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= '0;
            req_pc_q <= '0;
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else begin
            inflight <= imem_req;
            drop     <= redirect && inflight;
            if (redirect) begin
                pc_q <= {redirect_pc[PC_W-1:2], 2'b00};
            end else if (imem_req) begin
                pc_q     <= pc_q + PC_W'(4);
                req_pc_q <= pc_q;
            end
        end
    end

    fetch_fifo #(
        .W     (PC_W + INS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .din   ({req_pc_q, imem_rdata}),
        .dout  (head),
        .count (q_count)
    );

    assign ifid.if_valid = valid;
    assign ifid.if_pc    = valid ? head[PC_W+INS_W-1:INS_W] : '0;
    assign ifid.if_instr = valid ? head[INS_W-1:0]          : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Scenario bench for fetch_queue: expected {pc, instr} beats are queued as stimulus is
// applied and popped as the IF/ID side accepts them; imem model returns the address as data.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int PC_W  = FQ_PC_W;
    localparam int INS_W = FQ_INS_W;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             redirect = 1'b0;
    logic [PC_W-1:0]  redirect_pc = '0;
    logic             halt = 1'b0;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic [INS_W-1:0] imem_rdata = NOP_INSTR;
    logic [CW-1:0]    q_count;

    int vectors = 0;
    int miscompares = 0;
    fetch_entry_t exp_q[$];

    fetch_queue_if #(.PC_W(PC_W), .INS_W(INS_W)) ifid ();

    fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .ifid        (ifid),
        .q_count     (q_count)
    );

    always #5 clk = ~clk;

    // Instruction memory with one cycle of read latency; idle cycles return a NOP.
    always @(posedge clk) imem_rdata <= imem_req ? INS_W'(imem_addr) : NOP_INSTR;

    function automatic fetch_entry_t ent(input logic [PC_W-1:0] pc);
        ent.pc    = pc;
        ent.instr = INS_W'(pc);
    endfunction

    task automatic test_reset();
        fetch_entry_t e;
        reset = 1'b0;
        ifid.if_ready = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ifid.if_valid, q_count, imem_req} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl: valid=%b count=%0d req=%b, required all 0",
                     ifid.if_valid, q_count, imem_req);
        end
        vectors++;
        if (ifid.if_pc !== '0 || ifid.if_instr !== '0 || imem_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_data: pc=%h instr=%h addr=%h, required 0",
                     ifid.if_pc, ifid.if_instr, imem_addr);
        end
    endtask

    task automatic test_stream();
        fetch_entry_t e;
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(ent(PC_W'(4 * i)));
        @(negedge clk);
        vectors++;
        if (ifid.if_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_latency: valid=%b one cycle after release, required 0", ifid.if_valid);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (ifid.if_valid !== 1'b1 || ifid.if_pc !== e.pc || ifid.if_instr !== e.instr) begin
                miscompares++;
                $display("FAIL stream_beat%0d: valid=%b pc=%h instr=%h, required 1 %h %h",
                         i, ifid.if_valid, ifid.if_pc, ifid.if_instr, e.pc, e.instr);
            end
        end
    endtask

    task automatic test_backpressure();
        fetch_entry_t e;
        @(negedge clk);
        reset = 1'b0;
        ifid.if_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                vectors++;
                if (ifid.if_valid !== 1'b1 || ifid.if_pc !== '0) begin
                    miscompares++;
                    $display("FAIL bp_head%0d: valid=%b pc=%h, required 1 000", i, ifid.if_valid, ifid.if_pc);
                end
            end
        end
        vectors++;
        if (q_count !== CW'(DEPTH)) begin
            miscompares++;
            $display("FAIL bp_count: count=%0d, required %0d", q_count, DEPTH);
        end
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_req: imem_req=%b when full, required 0", imem_req);
        end
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(ent(PC_W'(4 * i)));
        ifid.if_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            vectors++;
            if (ifid.if_valid !== 1'b1 || ifid.if_pc !== e.pc || ifid.if_instr !== e.instr) begin
                miscompares++;
                $display("FAIL bp_drain%0d: valid=%b pc=%h instr=%h, required 1 %h %h",
                         i, ifid.if_valid, ifid.if_pc, ifid.if_instr, e.pc, e.instr);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        fetch_entry_t e;
        redirect = 1'b1;
        redirect_pc = 9'h040;
        #1;
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_req: imem_req=%b in redirect cycle, required 0", imem_req);
        end
        @(negedge clk);
        redirect = 1'b0;
        vectors++;
        if (ifid.if_valid !== 1'b0 || q_count !== '0) begin
            miscompares++;
            $display("FAIL redir_flush: valid=%b count=%0d, required 0 0", ifid.if_valid, q_count);
        end
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(ent(PC_W'(9'h040 + 4 * i)));
        for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (ifid.if_valid) begin
                e = exp_q.pop_front();
                vectors++;
                if (ifid.if_pc !== e.pc || ifid.if_instr !== e.instr) begin
                    miscompares++;
                    $display("FAIL redir_beat: pc=%h instr=%h, required %h %h",
                             ifid.if_pc, ifid.if_instr, e.pc, e.instr);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL redir_timeout: %0d beats missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_halt();
        fetch_entry_t e;
        bit found = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (imem_addr === 9'h020) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL halt_reach: imem_addr=%h, required 020 within budget", imem_addr);
        end
        vectors++;
        if (ifid.if_valid !== 1'b1 || ifid.if_pc !== 9'h018) begin
            miscompares++;
            $display("FAIL halt_head: valid=%b pc=%h, required 1 018", ifid.if_valid, ifid.if_pc);
        end
        halt = 1'b1;
        exp_q.delete();
        exp_q.push_back(ent(9'h01C));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if (imem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_req%0d: imem_req=%b, required 0", c, imem_req);
            end
            if (ifid.if_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL halt_extra: pc=%h, required no beat", ifid.if_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (ifid.if_pc !== e.pc || ifid.if_instr !== e.instr) begin
                        miscompares++;
                        $display("FAIL halt_beat: pc=%h instr=%h, required %h %h",
                                 ifid.if_pc, ifid.if_instr, e.pc, e.instr);
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0 || imem_addr !== 9'h020) begin
            miscompares++;
            $display("FAIL halt_state: missing=%0d addr=%h, required 0 020", exp_q.size(), imem_addr);
        end
        halt = 1'b0;
        exp_q.push_back(ent(9'h020));
        exp_q.push_back(ent(9'h024));
        for (int c = 0; c < 6 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (ifid.if_valid) begin
                e = exp_q.pop_front();
                vectors++;
                if (ifid.if_pc !== e.pc || ifid.if_instr !== e.instr) begin
                    miscompares++;
                    $display("FAIL resume_beat: pc=%h instr=%h, required %h %h",
                             ifid.if_pc, ifid.if_instr, e.pc, e.instr);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL resume_timeout: %0d beats missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        fetch_entry_t e;
        logic [PC_W-1:0] targets [2];
        targets[0] = 9'h1FC;
        targets[1] = 9'h043;
        for (int t = 0; t < 2; t++) begin
            redirect = 1'b1;
            redirect_pc = targets[t];
            @(negedge clk);
            redirect = 1'b0;
            exp_q.delete();
            if (t == 0) begin
                exp_q.push_back(ent(9'h1FC));
                exp_q.push_back(ent(9'h000));
                exp_q.push_back(ent(9'h004));
            end else begin
                exp_q.push_back(ent(9'h040));
                exp_q.push_back(ent(9'h044));
            end
            for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
                @(negedge clk);
                if (ifid.if_valid) begin
                    e = exp_q.pop_front();
                    vectors++;
                    if (ifid.if_pc !== e.pc || ifid.if_instr !== e.instr) begin
                        miscompares++;
                        $display("FAIL wrap_beat%0d: pc=%h instr=%h, required %h %h",
                                 t, ifid.if_pc, ifid.if_instr, e.pc, e.instr);
                    end
                end
            end
            vectors++;
            if (exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL wrap_timeout%0d: %0d beats missing, required 0", t, exp_q.size());
            end
        end
    endtask

    task automatic test_async_reset();
        fetch_entry_t e;
        bit found = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ifid.if_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (q_count === CW'(3)) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL ares_fill: count=%0d, required 3 within budget", q_count);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({ifid.if_valid, q_count, imem_req} !== '0) begin
            miscompares++;
            $display("FAIL ares_ctrl: valid=%b count=%0d req=%b, required all 0",
                     ifid.if_valid, q_count, imem_req);
        end
        vectors++;
        if (ifid.if_pc !== '0 || ifid.if_instr !== '0 || imem_addr !== '0) begin
            miscompares++;
            $display("FAIL ares_data: pc=%h instr=%h addr=%h, required 0",
                     ifid.if_pc, ifid.if_instr, imem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        ifid.if_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(ent(PC_W'(4 * i)));
        @(negedge clk);
        vectors++;
        if (ifid.if_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ares_latency: valid=%b, required 0", ifid.if_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (ifid.if_valid !== 1'b1 || ifid.if_pc !== e.pc || ifid.if_instr !== e.instr) begin
                miscompares++;
                $display("FAIL ares_beat%0d: valid=%b pc=%h instr=%h, required 1 %h %h",
                         i, ifid.if_valid, ifid.if_pc, ifid.if_instr, e.pc, e.instr);
            end
        end
    endtask

    initial begin
        ifid.if_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
